// File: rtl/btn_pkg.sv
// Shared constants for the push-button / LED controller.
package btn_pkg;
    localparam int   NUM_BUTTONS = 4;
    localparam int   LED_W       = 8;
    localparam logic BTN_IDLE    = 1'b1;

    localparam int BTN_INC = 0;
    localparam int BTN_DEC = 1;
    localparam int BTN_ROT = 2;
    localparam int BTN_CLR = 3;
endpackage

// File: rtl/button_debouncer.sv
// One push button: 2-flop synchronizer, hold-time debounce, registered press pulse.
module button_debouncer
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q;
    logic             db_state;
    logic             db_prev;
    logic [CNT_W-1:0] cnt;
    logic             sync;

    assign sync = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= {2{BTN_IDLE}};
            db_state <= BTN_IDLE;
            db_prev  <= BTN_IDLE;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            db_prev <= db_state;
            // Counter tops out at DEBOUNCE_CYCLES-1, where the new level is accepted.
            if (sync == db_state) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_state <= sync;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            press <= db_prev & ~db_state;
        end
    end
endmodule

// File: rtl/button_led_ctrl.sv
// Button receive path: differential clock input, per-button debounce, LED register edits.
module button_led_ctrl
    import btn_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [LED_W-1:0] LED_RESET       = 8'h00
) (
    input  logic                   sys_clkp,
    input  logic                   sys_clkn,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] button,
    output logic [LED_W-1:0]       led,
    output logic [NUM_BUTTONS-1:0] press
);
    logic             clk;
    logic [LED_W-1:0] led_nxt;

    // Differential input buffer: legs are complementary, so this follows sys_clkp.
    assign clk = sys_clkp & ~sys_clkn;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (reset),
            .btn  (button[g]),
            .press(press[g])
        );
    end

    always_comb begin
        led_nxt = led;
        if (press[BTN_CLR])
            led_nxt = LED_RESET;
        else if (press[BTN_ROT])
            led_nxt = {led[LED_W-2:0], led[LED_W-1]};
        else if (press[BTN_INC] && !press[BTN_DEC])
            led_nxt = led + 1'b1;
        else if (press[BTN_DEC] && !press[BTN_INC])
            led_nxt = led - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) led <= LED_RESET;
        else       led <= led_nxt;
    end
endmodule

// File: tb/tb_button_led_ctrl.sv
// Directed bench for button_led_ctrl with DEBOUNCE_CYCLES=4 and a 10 ns clock.
module tb_button_led_ctrl;
    logic       sys_clkp = 1'b0;
    logic       sys_clkn;
    logic       reset;
    logic [3:0] button;
    logic [7:0] led;
    logic [3:0] press;

    int passed = 0;
    int total  = 0;
    int pc[4];

    localparam logic [3:0] M_INC = 4'b0001;
    localparam logic [3:0] M_DEC = 4'b0010;
    localparam logic [3:0] M_ROT = 4'b0100;
    localparam logic [3:0] M_CLR = 4'b1000;

    assign sys_clkn = ~sys_clkp;
    always #5 sys_clkp = ~sys_clkp;

    button_led_ctrl #(.DEBOUNCE_CYCLES(4), .LED_RESET(8'h00)) dut (
        .sys_clkp(sys_clkp),
        .sys_clkn(sys_clkn),
        .reset   (reset),
        .button  (button),
        .led     (led),
        .press   (press)
    );

    task automatic clr_pc();
        for (int i = 0; i < 4; i++) pc[i] = 0;
    endtask

    // Advance n rising edges, sampling 1 ns after each and counting press pulses.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge sys_clkp);
            #1;
            for (int i = 0; i < 4; i++) if (press[i]) pc[i]++;
        end
    endtask

    // Hold the buttons in mask low long enough to be accepted, then release fully.
    task automatic push(input logic [3:0] mask);
        @(negedge sys_clkp);
        button = ~mask;
        tick(8);
        @(negedge sys_clkp);
        button = 4'hF;
        tick(8);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        button = 4'hF;
        #12;
        total++;
        if (led !== 8'h00) $display("FAIL reset_led got %h want 00", led); else passed++;
        total++;
        if (press !== 4'h0) $display("FAIL reset_press got %b want 0000", press); else passed++;
        @(negedge sys_clkp);
        reset = 1'b0;
        clr_pc();
        tick(8);
        total++;
        if (pc[0] + pc[1] + pc[2] + pc[3] != 0)
            $display("FAIL reset_release_pulse got %0d pulses want 0", pc[0] + pc[1] + pc[2] + pc[3]);
        else passed++;
        total++;
        if (led !== 8'h00) $display("FAIL reset_release_led got %h want 00", led); else passed++;
    endtask

    task automatic test_glitch();
        clr_pc();
        @(negedge sys_clkp);
        button = 4'b1110;
        @(negedge sys_clkp);
        button = 4'hF;
        tick(20);
        total++;
        if (pc[0] != 0) $display("FAIL glitch_pulse got %0d want 0", pc[0]); else passed++;
        total++;
        if (led !== 8'h00) $display("FAIL glitch_led got %h want 00", led); else passed++;
    endtask

    task automatic test_clean_press();
        clr_pc();
        @(negedge sys_clkp);
        button = 4'b1110;
        tick(6);
        total++;
        if (pc[0] != 0 || led !== 8'h00)
            $display("FAIL press_early got pulses=%0d led=%h want 0/00", pc[0], led);
        else passed++;
        tick(1);
        total++;
        if (press !== 4'b0001) $display("FAIL press_pulse got %b want 0001", press); else passed++;
        tick(1);
        total++;
        if (led !== 8'h01 || press !== 4'b0000)
            $display("FAIL press_led got led=%h press=%b want 01/0000", led, press);
        else passed++;
        tick(2);
        @(negedge sys_clkp);
        button = 4'hF;
        tick(12);
        total++;
        if (pc[0] != 1 || led !== 8'h01)
            $display("FAIL press_hold_release got pulses=%0d led=%h want 1/01", pc[0], led);
        else passed++;
    endtask

    task automatic test_wrap_rotate();
        push(M_CLR);
        total++;
        if (led !== 8'h00) $display("FAIL clear got %h want 00", led); else passed++;
        push(M_DEC);
        total++;
        if (led !== 8'hFF) $display("FAIL dec_wrap got %h want FF", led); else passed++;
        push(M_INC);
        total++;
        if (led !== 8'h00) $display("FAIL inc_wrap got %h want 00", led); else passed++;
        push(M_INC);
        for (int i = 0; i < 7; i++) push(M_ROT);
        total++;
        if (led !== 8'h80) $display("FAIL rot_build got %h want 80", led); else passed++;
        push(M_ROT);
        total++;
        if (led !== 8'h01) $display("FAIL rot_wrap got %h want 01", led); else passed++;
    endtask

    task automatic test_simultaneous();
        clr_pc();
        push(M_INC | M_DEC);
        total++;
        if (pc[0] != 1 || pc[1] != 1)
            $display("FAIL incdec_pulses got %0d/%0d want 1/1", pc[0], pc[1]);
        else passed++;
        total++;
        if (led !== 8'h01) $display("FAIL incdec_hold got %h want 01", led); else passed++;
        push(M_CLR);
        for (int i = 0; i < 45; i++) push(M_INC);
        total++;
        if (led !== 8'h2D) $display("FAIL inc_count got %h want 2D", led); else passed++;
        push(M_ROT);
        total++;
        if (led !== 8'h5A) $display("FAIL rot_5a got %h want 5A", led); else passed++;
        push(M_CLR | M_ROT);
        total++;
        if (led !== 8'h00) $display("FAIL clr_over_rot got %h want 00", led); else passed++;
    endtask

    task automatic test_bounce();
        clr_pc();
        for (int p = 0; p < 4; p++) begin
            @(negedge sys_clkp);
            button = (p % 2 == 0) ? 4'b1110 : 4'b1111;
            tick(2);
        end
        @(negedge sys_clkp);
        button = 4'b1110;
        tick(6);
        total++;
        if (pc[0] != 0) $display("FAIL bounce_early got %0d pulses want 0", pc[0]); else passed++;
        tick(1);
        total++;
        if (press !== 4'b0001) $display("FAIL bounce_pulse got %b want 0001", press); else passed++;
        tick(1);
        total++;
        if (led !== 8'h01) $display("FAIL bounce_led got %h want 01", led); else passed++;
        @(negedge sys_clkp);
        button = 4'hF;
        tick(10);
        total++;
        if (pc[0] != 1) $display("FAIL bounce_count got %0d want 1", pc[0]); else passed++;
    endtask

    task automatic test_reset_mid();
        clr_pc();
        @(negedge sys_clkp);
        button = 4'b1011;
        tick(4);
        #2 reset = 1'b1;
        #1;
        total++;
        if (led !== 8'h00) $display("FAIL midreset_led got %h want 00", led); else passed++;
        @(negedge sys_clkp);
        button = 4'hF;
        tick(2);
        @(negedge sys_clkp);
        reset = 1'b0;
        tick(12);
        total++;
        if (pc[0] + pc[1] + pc[2] + pc[3] != 0 || led !== 8'h00)
            $display("FAIL midreset_after got pulses=%0d led=%h want 0/00",
                     pc[0] + pc[1] + pc[2] + pc[3], led);
        else passed++;
    endtask

    task automatic test_held_over_reset();
        clr_pc();
        @(negedge sys_clkp);
        button = 4'b1110;
        tick(3);
        reset = 1'b1;
        tick(2);
        @(negedge sys_clkp);
        reset = 1'b0;
        tick(6);
        total++;
        if (pc[0] != 0) $display("FAIL held_early got %0d pulses want 0", pc[0]); else passed++;
        tick(1);
        total++;
        if (press !== 4'b0001) $display("FAIL held_pulse got %b want 0001", press); else passed++;
        tick(1);
        total++;
        if (led !== 8'h01) $display("FAIL held_led got %h want 01", led); else passed++;
        @(negedge sys_clkp);
        button = 4'hF;
        tick(8);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_clean_press();
        test_wrap_rotate();
        test_simultaneous();
        test_bounce();
        test_reset_mid();
        test_held_over_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
